// File: rtl/imm_ext_pkg.sv
// Shared mode codes and field widths for the LC-3 immediate extractor.
package imm_ext_pkg;

  localparam logic [2:0] MODE_IMM5  = 3'd0;
  localparam logic [2:0] MODE_OFF6  = 3'd1;
  localparam logic [2:0] MODE_PC9   = 3'd2;
  localparam logic [2:0] MODE_PC11  = 3'd3;
  localparam logic [2:0] MODE_TRAP8 = 3'd4;
  localparam logic [2:0] MODE_AMT4  = 3'd5;

  localparam int unsigned W_IMM5  = 5;
  localparam int unsigned W_OFF6  = 6;
  localparam int unsigned W_PC9   = 9;
  localparam int unsigned W_PC11  = 11;
  localparam int unsigned W_TRAP8 = 8;
  localparam int unsigned W_AMT4  = 4;

endpackage

// File: rtl/imm_field_ext.sv
// Combinational LC-3 field select and sign/zero extension.
// Optional left-shift-by-one when IMM_EXT_LSHF1_EN is defined.
module imm_field_ext
  import imm_ext_pkg::*;
#(
  parameter int unsigned IR_W  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IR_W-1:0]  ir,
  input  logic [2:0]       mode,
  input  logic             sext,
  input  logic             lshf,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  logic [OUT_W-1:0] ext;

  // Opcode and register fields above the widest immediate are never used here.
  logic unused_ir;
  assign unused_ir = ^ir[IR_W-1:W_PC11];

  always_comb begin
    ext = '0;
    err = 1'b0;
    case (mode)
      MODE_IMM5:  ext = {{(OUT_W-W_IMM5){sext & ir[W_IMM5-1]}}, ir[W_IMM5-1:0]};
      MODE_OFF6:  ext = {{(OUT_W-W_OFF6){sext & ir[W_OFF6-1]}}, ir[W_OFF6-1:0]};
      MODE_PC9:   ext = {{(OUT_W-W_PC9){sext & ir[W_PC9-1]}}, ir[W_PC9-1:0]};
      MODE_PC11:  ext = {{(OUT_W-W_PC11){sext & ir[W_PC11-1]}}, ir[W_PC11-1:0]};
      MODE_TRAP8: ext = {{(OUT_W-W_TRAP8){1'b0}}, ir[W_TRAP8-1:0]};
      MODE_AMT4:  ext = {{(OUT_W-W_AMT4){1'b0}}, ir[W_AMT4-1:0]};
      default:    err = 1'b1;
    endcase
  end

`ifdef IMM_EXT_LSHF1_EN
  assign data = lshf ? {ext[OUT_W-2:0], 1'b0} : ext;
`else
  logic unused_lshf;
  assign unused_lshf = lshf;
  assign data        = ext;
`endif

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready pipeline around imm_field_ext for the LC-3 datapath.
// IMM_EXT_LSHF1_EN enables the optional left-shift-by-one in stage 1.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IR_W  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  in_ir,
  input  logic [2:0]       in_mode,
  input  logic             in_sext,
  input  logic             in_lshf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  if (OUT_W < 12) begin : g_out_w_check
    $error("imm_ext_pipe: OUT_W must be >= 12");
  end

  logic [OUT_W-1:0] fe_data;
  logic             fe_err;

  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_data_q, s1_data_d;
  logic             s1_err_q, s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_data_q, s2_data_d;
  logic             s2_err_q, s2_err_d;

  logic s2_load;
  logic accept;

  imm_field_ext #(
    .IR_W  (IR_W),
    .OUT_W (OUT_W)
  ) u_field_ext (
    .ir   (in_ir),
    .mode (in_mode),
    .sext (in_sext),
    .lshf (in_lshf),
    .data (fe_data),
    .err  (fe_err)
  );

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    // Flush drops everything in flight but leaves the data registers untouched.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_data_d  = fe_data;
        s1_err_d   = fe_err;
      end else if (s2_load) begin
        s1_valid_d = 1'b0;
      end
      if (s2_load) begin
        s2_valid_d = 1'b1;
        s2_data_d  = s1_data_q;
        s2_err_d   = s1_err_q;
      end else if (out_ready) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe: modes, latency, backpressure, flush, reset.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ir;
  logic [2:0]  in_mode;
  logic        in_sext;
  logic        in_lshf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(
    .IR_W  (16),
    .OUT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_mode   (in_mode),
    .in_sext   (in_sext),
    .in_lshf   (in_lshf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // {ir, mode, sext, expected data, expected err}
  localparam int NVEC = 14;
  localparam logic [36:0] VECS [0:NVEC-1] = '{
    {16'h001F, 3'd0, 1'b1, 16'hFFFF, 1'b0},
    {16'h001F, 3'd0, 1'b0, 16'h001F, 1'b0},
    {16'hFFEF, 3'd0, 1'b1, 16'h000F, 1'b0},
    {16'hFFDF, 3'd1, 1'b1, 16'h001F, 1'b0},
    {16'h0100, 3'd2, 1'b1, 16'hFF00, 1'b0},
    {16'h0100, 3'd2, 1'b0, 16'h0100, 1'b0},
    {16'h0400, 3'd3, 1'b1, 16'hFC00, 1'b0},
    {16'h0400, 3'd3, 1'b0, 16'h0400, 1'b0},
    {16'h00FF, 3'd4, 1'b1, 16'h00FF, 1'b0},
    {16'hFFFF, 3'd5, 1'b1, 16'h000F, 1'b0},
    {16'h1234, 3'd6, 1'b1, 16'h0000, 1'b1},
    {16'h0020, 3'd1, 1'b1, 16'hFFE0, 1'b0},
    {16'hFFFF, 3'd7, 1'b0, 16'h0000, 1'b1},
    {16'hFF80, 3'd4, 1'b1, 16'h0080, 1'b0}
  };

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_ir    = '0;
    in_mode  = '0;
    in_sext  = 1'b0;
    in_lshf  = 1'b0;
  endtask

  // Single request with out_ready=1; reports result and accept-to-valid latency in cycles.
  task automatic send_one(input logic [15:0] ir, input logic [2:0] mode, input logic sext,
                          input logic lshf, output logic [15:0] data, output logic err,
                          output int lat, output bit got);
    int waitc;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ir     = ir;
    in_mode   = mode;
    in_sext   = sext;
    in_lshf   = lshf;
    waitc     = 0;
    #1;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    got  = out_valid;
    data = out_data;
    err  = out_err;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data);
    end
    n_checks++;
    if (out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_modes();
    logic [36:0] v;
    logic [15:0] d;
    logic        e;
    int          lat;
    bit          got;
    for (int i = 0; i < NVEC; i++) begin
      v = VECS[i];
      send_one(v[36:21], v[20:18], v[17], 1'b0, d, e, lat, got);
      n_checks++;
      if (!got || lat != 2) begin
        n_fail++; $display("FAIL mode_latency[%0d]: got %0d cycles (valid %b) expected 2", i, lat, got);
      end
      n_checks++;
      if (d !== v[16:1]) begin
        n_fail++; $display("FAIL mode_data[%0d]: got %h expected %h", i, d, v[16:1]);
      end
      n_checks++;
      if (e !== v[0]) begin
        n_fail++; $display("FAIL mode_err[%0d]: got %b expected %b", i, e, v[0]);
      end
    end
  endtask

  task automatic test_lshf();
    logic [15:0] d;
    logic [15:0] exp_d;
    logic        e;
    int          lat;
    bit          got;
`ifdef IMM_EXT_LSHF1_EN
    exp_d = 16'hFFFE;
`else
    exp_d = 16'hFFFF;
`endif
    send_one(16'h003F, 3'd1, 1'b1, 1'b1, d, e, lat, got);
    n_checks++;
    if (!got || lat != 2 || d !== exp_d || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lshf_off6: got %h err %b lat %0d expected %h err 0 lat 2", d, e, lat, exp_d);
    end
`ifdef IMM_EXT_LSHF1_EN
    exp_d = 16'hF800;
`else
    exp_d = 16'hFC00;
`endif
    send_one(16'h0400, 3'd3, 1'b1, 1'b1, d, e, lat, got);
    n_checks++;
    if (!got || d !== exp_d) begin
      n_fail++; $display("FAIL lshf_pc11: got %h expected %h", d, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    int          acc;
    logic [15:0] got_d [$];
    int          rcv_cyc [$];
    acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (acc < 4);
      in_ir     = 16'(acc + 1);
      in_mode   = 3'd0;
      in_sext   = 1'b0;
      in_lshf   = 1'b0;
      #1;
      if (cyc == 2) begin
        n_checks++;
        if (acc != 2 || in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready: got accepts %0d in_ready %b expected 2 and 0", acc, in_ready);
        end
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got valid %b data %h expected 1 0001", cyc, out_valid, out_data);
        end
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        rcv_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got_d.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d results expected 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_d[i] !== 16'(i + 1)) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_d[i], 16'(i + 1));
        end
      end
      n_checks++;
      if (rcv_cyc[0] != 5 || rcv_cyc[3] - rcv_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL bp_rate: got first %0d last %0d expected 5 and 8", rcv_cyc[0], rcv_cyc[3]);
      end
    end
  endtask

  task automatic test_flush();
    int          seen;
    logic [15:0] d;
    logic        e;
    int          lat;
    bit          got;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 16'h0011;
    in_mode   = 3'd0;
    in_sext   = 1'b0;
    @(negedge clk);
    in_ir = 16'h0005;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0011 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: got valid %b data %h in_ready %b expected 1 0011 0", out_valid,
               out_data, in_ready);
    end
    out_ready = 1'b1;
    in_ir     = 16'h001A;
    in_sext   = 1'b1;
    flush     = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_accept_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0011) begin
      n_fail++;
      $display("FAIL flush_clear: got valid %b data %h expected 0 0011", out_valid, out_data);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_dropped: got %0d stray results expected 0", seen);
    end
    send_one(16'h0007, 3'd5, 1'b1, 1'b0, d, e, lat, got);
    n_checks++;
    if (!got || lat != 2 || d !== 16'h0007 || e !== 1'b0) begin
      n_fail++; $display("FAIL flush_recover: got %h lat %0d expected 0007 lat 2", d, lat);
    end
  endtask

  task automatic test_reset_mid();
    int          seen;
    logic [15:0] d;
    logic        e;
    int          lat;
    bit          got;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 16'h001F;
    in_mode   = 3'd0;
    in_sext   = 1'b1;
    @(negedge clk);
    in_ir = 16'h0003;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
      n_fail++; $display("FAIL rstmid_pre: got valid %b data %h expected 1 FFFF", out_valid, out_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_async: got valid %b data %h err %b in_ready %b expected 0 0000 0 1",
               out_valid, out_data, out_err, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rstmid_lost: got %0d stray results expected 0", seen);
    end
    send_one(16'h0020, 3'd1, 1'b1, 1'b0, d, e, lat, got);
    n_checks++;
    if (!got || lat != 2 || d !== 16'hFFE0 || e !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_recover: got %h lat %0d expected FFE0 lat 2", d, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_modes();
    test_lshf();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
